pla_sweep_ctrl: RTL and testbench
=================================

// Module: pla_sweep_ctrl
// PURPOSE
//  Exhaustive-sweep sequencer for one single-output combinational PLA benchmark netlist (x0..x14 -> y0).
//  Drives every input minterm 0..2^N_IN-1 in order and samples y0 for each one.
//  Reports the on-set size and the first on-set minterm.
//  Sits between the experiment harness (start/abort/results) and the benchmark instance (x_out/y_in).
// PARAMETERS
//  N_IN   15        number of benchmark inputs; x_out[i] drives xi
//  LAT    0         register stages between x_out and y_in (0 = purely combinational DUT)
//  CNT_W  N_IN+1    onset_cnt width; must hold 2^N_IN
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  start         in   1       request a sweep; honoured only in IDLE
//  abort         in   1       cancel a running sweep
//  busy          out  1       high in RUN and DRAIN
//  done          out  1       one-cycle pulse when results are final
//  x_out         out  N_IN    minterm applied to the benchmark
//  y_in          in   1       benchmark output y0
//  onset_cnt     out  CNT_W   number of minterms with y_in=1
//  first_on      out  N_IN    lowest minterm with y_in=1
//  first_on_vld  out  1       first_on holds a valid minterm
//  signature     out  16      MISR of the y_in stream (PLA_SIG_MISR_EN only)
// BEHAVIOUR
//  States: IDLE, RUN, DRAIN, DONE. rst forces IDLE asynchronously and zeroes every output and counter; signature reset value is 16'hFFFF.
//  IDLE: start=1 at edge E0 -> RUN, addr<=0, onset_cnt/first_on/first_on_vld<=0, signature<=16'hFFFF.
//  RUN: x_out=addr; addr increments each cycle. RUN cycle i (i=1..2^N_IN) presents minterm i-1.
//   After minterm 2^N_IN-1: DRAIN if LAT>0, else DONE. addr wraps to 0.
//  Capture: a LAT-deep valid/tag shift register travels with addr. y_in for minterm m is sampled at the edge that ends cycle (m+1+LAT).
//   y_in=1 -> onset_cnt++. On the first hit: first_on<=tag, first_on_vld<=1.
//  DRAIN: lasts exactly LAT cycles. x_out holds 0. No new valid tags are issued.
//  DONE: lasts one cycle with done=1 (cycle 2^N_IN+LAT+1 after E0), then IDLE. Results hold until the next accepted start.
//  x_out=0 in IDLE, DRAIN and DONE.
//  start while busy or in DONE: ignored.
//  abort in RUN/DRAIN: next state IDLE. No done pulse. Results cleared to reset values. In-flight tags discarded.
//  abort and start in the same IDLE cycle: abort wins and start is dropped.
//  abort in IDLE/DONE: no effect.
//  All-ones function: onset_cnt = 2^N_IN with no overflow. CNT_W < N_IN+1 is illegal.
// CONFIGURATION
//  `PLA_SIG_MISR_EN defined:
//   - signature port present. 16-bit Fibonacci MISR, poly x^16+x^14+x^13+x^11+1, seed 16'hFFFF.
//   - Each valid capture: sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]^y_in}.
//   - Frozen outside valid captures.
//  Undefined: signature port and MISR logic absent. All other behaviour identical.
// TESTING
//  T1 N_IN=4,LAT=0, y_in=0: start at E0 -> busy cycles 1..16, done in cycle 17, onset_cnt=0, first_on_vld=0.
//  T2 N_IN=4,LAT=0, y_in=(x_out==4'd5): onset_cnt=1, first_on=5, first_on_vld=1.
//  T3 N_IN=4,LAT=2, y_in=x_out[0] via 2-flop delay: onset_cnt=8, first_on=1, done in cycle 19, x_out=0 in cycles 17..18.
//  T4 N_IN=4, abort in cycle 6: busy low from cycle 7, no done, onset_cnt=0. Second start completes as T1.
//  T5 N_IN=15, y_in=1: onset_cnt=32768, first_on=0, done in cycle 32769. rst pulse mid-RUN zeroes outputs in the same cycle.
//  T6 MISR_EN, N_IN=4, T3 stimulus: signature equals bench software-LFSR model. Inverting one y_in sample changes the signature.

Source files
------------

// File: rtl/pla_sweep_ctrl.sv
// Exhaustive minterm sweep sequencer for a single-output PLA benchmark: counts the on-set and finds the lowest on-set minterm.
// Optional MISR signature of the y_in stream is enabled with `PLA_SIG_MISR_EN.
module pla_sweep_ctrl #(
    parameter int N_IN  = 15,
    parameter int LAT   = 0,
    parameter int CNT_W = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [N_IN-1:0]  x_out,
    input  logic             y_in,
    output logic [CNT_W-1:0] onset_cnt,
    output logic [N_IN-1:0]  first_on,
    output logic             first_on_vld
`ifdef PLA_SIG_MISR_EN
    ,
    output logic [15:0]      signature
`endif
);

    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            r_state, w_next;
    logic [N_IN-1:0]   r_addr;
    logic [DW-1:0]     r_dcnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_IN-1:0]   r_first;
    logic              r_fvld;
    logic              w_last, w_start_ok, w_abort, w_flush, w_vld0;
    logic              w_cap_vld;
    logic [N_IN-1:0]   w_cap_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_last     = (r_addr == {N_IN{1'b1}});
        w_start_ok = (r_state == IDLE) && start && !abort;
        w_abort    = abort && ((r_state == RUN) || (r_state == DRAIN));
        w_flush    = w_start_ok || w_abort;
        w_vld0     = (r_state == RUN);
        case (r_state)
            IDLE:  if (w_start_ok) w_next = RUN;
            RUN: begin
                if (abort)       w_next = IDLE;
                else if (w_last) w_next = (LAT > 0) ? DRAIN : DONE;
            end
            DRAIN: begin
                if (abort)                      w_next = IDLE;
                else if (r_dcnt == DW'(LAT-1))  w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Valid/tag pipeline mirrors the benchmark's register latency so each y_in is paired with its minterm.
    generate
        if (LAT == 0) begin : g_nolat
            assign w_cap_vld = w_vld0;
            assign w_cap_tag = r_addr;
        end else begin : g_lat
            logic [LAT-1:0]           r_vld_pipe;
            logic [LAT-1:0][N_IN-1:0] r_tag_pipe;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld_pipe <= '0;
                    r_tag_pipe <= '0;
                end else begin
                    r_vld_pipe[0] <= w_vld0 && !w_flush;
                    r_tag_pipe[0] <= r_addr;
                    for (int k = 1; k < LAT; k++) begin
                        r_vld_pipe[k] <= r_vld_pipe[k-1] && !w_flush;
                        r_tag_pipe[k] <= r_tag_pipe[k-1];
                    end
                end
            end
            assign w_cap_vld = r_vld_pipe[LAT-1];
            assign w_cap_tag = r_tag_pipe[LAT-1];
        end
    endgenerate

`ifdef PLA_SIG_MISR_EN
    logic [15:0] r_sig;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_dcnt  <= '0;
            r_cnt   <= '0;
            r_first <= '0;
            r_fvld  <= 1'b0;
`ifdef PLA_SIG_MISR_EN
            r_sig   <= 16'hFFFF;
`endif
        end else begin
            r_dcnt <= (r_state == DRAIN) ? r_dcnt + 1'b1 : '0;
            if (w_flush) begin
                r_addr  <= '0;
                r_cnt   <= '0;
                r_first <= '0;
                r_fvld  <= 1'b0;
`ifdef PLA_SIG_MISR_EN
                r_sig   <= 16'hFFFF;
`endif
            end else begin
                if (r_state == RUN) r_addr <= r_addr + 1'b1;
                if (w_cap_vld && y_in) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!r_fvld) begin
                        r_first <= w_cap_tag;
                        r_fvld  <= 1'b1;
                    end
                end
`ifdef PLA_SIG_MISR_EN
                if (w_cap_vld)
                    r_sig <= {r_sig[14:0], r_sig[15] ^ r_sig[13] ^ r_sig[12] ^ r_sig[10] ^ y_in};
`endif
            end
        end
    end

    assign busy         = (r_state == RUN) || (r_state == DRAIN);
    assign done         = (r_state == DONE);
    assign x_out        = (r_state == RUN) ? r_addr : '0;
    assign onset_cnt    = r_cnt;
    assign first_on     = r_first;
    assign first_on_vld = r_fvld;
`ifdef PLA_SIG_MISR_EN
    assign signature    = r_sig;
`endif

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Directed bench: three sweep controllers (4-bit/LAT0, 4-bit/LAT2, 15-bit/LAT0) with a results scoreboard.
module tb_pla_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, rst15 = 1'b1;
    logic start0 = 0, abort0 = 0, start2 = 0, abort2 = 0, start15 = 0, abort15 = 0;
    logic busy0, done0, fvld0, busy2, done2, fvld2, busy15, done15, fvld15;
    logic [3:0]  x0, x2, first0, first2;
    logic [4:0]  cnt0, cnt2;
    logic [14:0] x15, first15;
    logic [15:0] cnt15;
    logic        y0, y15;
    logic        d1 = 1'b0, d2 = 1'b0;
    logic [15:0] sig0, sig2, sig15;

    int fmode = 0, inv_m = -1, mode15 = 1;
    bit sel = 0;
    int ncmp = 0, nfail = 0;

    typedef struct {int cnt; int first; bit vld; logic [15:0] sig;} exp_t;
    exp_t sb[$];

    function automatic bit fn(int mode, int m);
        case (mode)
            1:       return (m == 5);
            2:       return m[0];
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign y0  = fn(fmode, int'(x0)) ^ (int'(x0) == inv_m);
    assign y15 = mode15[0];
    always @(posedge clk) begin
        d1 <= fn(fmode, int'(x2)) ^ (int'(x2) == inv_m);
        d2 <= d1;
    end

    pla_sweep_ctrl #(.N_IN(4), .LAT(0), .CNT_W(5)) u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .busy(busy0), .done(done0),
        .x_out(x0), .y_in(y0), .onset_cnt(cnt0), .first_on(first0), .first_on_vld(fvld0)
`ifdef PLA_SIG_MISR_EN
        , .signature(sig0)
`endif
    );
    pla_sweep_ctrl #(.N_IN(4), .LAT(2), .CNT_W(5)) u2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .busy(busy2), .done(done2),
        .x_out(x2), .y_in(d2), .onset_cnt(cnt2), .first_on(first2), .first_on_vld(fvld2)
`ifdef PLA_SIG_MISR_EN
        , .signature(sig2)
`endif
    );
    pla_sweep_ctrl #(.N_IN(15), .LAT(0), .CNT_W(16)) u15 (
        .clk(clk), .rst(rst15), .start(start15), .abort(abort15), .busy(busy15), .done(done15),
        .x_out(x15), .y_in(y15), .onset_cnt(cnt15), .first_on(first15), .first_on_vld(fvld15)
`ifdef PLA_SIG_MISR_EN
        , .signature(sig15)
`endif
    );
`ifndef PLA_SIG_MISR_EN
    assign sig0 = 16'hFFFF;
    assign sig2 = 16'hFFFF;
    assign sig15 = 16'hFFFF;
`endif

    logic       busy_s, done_s, fvld_s;
    logic [3:0] x_s, first_s;
    logic [4:0] cnt_s;
    logic [15:0] sig_s;
    assign busy_s  = sel ? busy2 : busy0;
    assign done_s  = sel ? done2 : done0;
    assign fvld_s  = sel ? fvld2 : fvld0;
    assign x_s     = sel ? x2 : x0;
    assign first_s = sel ? first2 : first0;
    assign cnt_s   = sel ? cnt2 : cnt0;
    assign sig_s   = sel ? sig2 : sig0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sweep on the 4-bit DUT chosen by s; abort_cyc=0 means run to completion.
    task automatic sweep(input bit s, input int mode, input int inv, input int abort_cyc,
                         output logic [15:0] sig_out);
        int lat = s ? 2 : 0;
        int ecnt = 0, efirst = 0;
        bit evld = 0, y;
        logic [15:0] esig = 16'hFFFF;
        exp_t e;
        sel = s; fmode = mode; inv_m = inv;
        for (int m = 0; m < 16; m++) begin
            y = fn(mode, m) ^ (m == inv);
            if (y) begin
                if (!evld) begin efirst = m; evld = 1; end
                ecnt++;
            end
            esig = {esig[14:0], esig[15] ^ esig[13] ^ esig[12] ^ esig[10] ^ y};
        end
        if (abort_cyc == 0) sb.push_back('{ecnt, efirst, evld, esig});
        if (s) start2 = 1; else start0 = 1;
        tick();
        start0 = 0; start2 = 0;
        for (int c = 1; c <= 18 + lat; c++) begin
            chk("busy", 32'(busy_s), (abort_cyc != 0) ? 32'(c <= abort_cyc) : 32'(c <= 16 + lat));
            chk("x_out", 32'(x_s), (c <= 16 && (abort_cyc == 0 || c <= abort_cyc)) ? c - 1 : 0);
            chk("done", 32'(done_s), 32'(abort_cyc == 0 && c == 17 + lat));
            if (done_s === 1'b1) begin
                chk("sb_has_entry", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("onset_cnt", 32'(cnt_s), e.cnt);
                    chk("first_on", 32'(first_s), e.first);
                    chk("first_on_vld", 32'(fvld_s), 32'(e.vld));
`ifdef PLA_SIG_MISR_EN
                    chk("signature", 32'(sig_s), 32'(e.sig));
`endif
                end
            end
            // start mid-RUN is ignored; start+abort in DONE/IDLE must not launch a sweep
            if (c == 3 || c == 17 + lat) begin
                if (s) start2 = 1; else start0 = 1;
            end
            if (c == abort_cyc || c == 17 + lat) begin
                if (s) abort2 = 1; else abort0 = 1;
            end
            tick();
            start0 = 0; start2 = 0; abort0 = 0; abort2 = 0;
        end
        chk("sb_drained", 32'(sb.size()), 0);
        chk("hold_cnt", 32'(cnt_s), (abort_cyc == 0) ? ecnt : 0);
        chk("hold_vld", 32'(fvld_s), (abort_cyc == 0) ? 32'(evld) : 0);
        sig_out = sig_s;
    endtask

    initial begin
        logic [15:0] sa, sb_sig;
        int c15;
        tick();
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_x", 32'(x0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_fvld", 32'(fvld0), 0);
        chk("rst_sig", 32'(sig0), 32'hFFFF);
        rst = 0; rst15 = 0;
        tick();

        sweep(0, 0, -1, 0, sa);   // T1: empty on-set
        sweep(0, 1, -1, 0, sa);   // T2: single minterm 5
        sweep(1, 2, -1, 0, sa);   // T3: odd minterms through 2-flop delay
        sweep(0, 2, -1, 6, sa);   // T4: abort in cycle 6
        sweep(0, 0, -1, 0, sa);   // T4: follow-up sweep completes
        sweep(1, 2, -1, 0, sa);   // T6: reference signature
        sweep(1, 2, 7, 0, sb_sig); // T6: minterm 7 sample inverted
`ifdef PLA_SIG_MISR_EN
        chk("sig_changes", 32'(sa !== sb_sig), 1);
`endif
        sweep(0, 3, -1, 0, sa);   // all-ones, 4-bit: count 16 without overflow

        // T5: full 15-input sweep with y_in=1
        mode15 = 1;
        start15 = 1;
        tick();
        start15 = 0;
        c15 = 1;
        while (done15 !== 1'b1 && c15 < 32800) begin
            tick();
            c15++;
        end
        chk("t5_done_seen", 32'(done15), 1);
        chk("t5_done_cycle", 32'(c15), 32769);
        chk("t5_cnt", 32'(cnt15), 32768);
        chk("t5_first", 32'(first15), 0);
        chk("t5_fvld", 32'(fvld15), 1);

        tick();
        start15 = 1;
        tick();
        start15 = 0;
        repeat (100) tick();
        chk("t5_busy_pre", 32'(busy15), 1);
        rst15 = 1;
        #1;
        chk("t5_rst_busy", 32'(busy15), 0);
        chk("t5_rst_x", 32'(x15), 0);
        chk("t5_rst_cnt", 32'(cnt15), 0);
        chk("t5_rst_fvld", 32'(fvld15), 0);
        chk("t5_rst_first", 32'(first15), 0);
        chk("t5_rst_sig", 32'(sig15), 32'hFFFF);
        tick();
        rst15 = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
